// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder: op encodings and
// default geometry (64-bit operands, 8-bit lookahead slices, 2 pipeline stages).
package cla_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } cla_op_e;

  localparam int DEF_WIDTH  = 64;
  localparam int DEF_BLK    = 8;
  localparam int DEF_STAGES = 2;

endpackage

// File: rtl/cla_blk.sv
// One carry-lookahead slice: generate/propagate per bit, every internal carry
// expanded as a flat sum-of-products of g, p and the slice carry-in.
module cla_blk #(
  parameter int BLK = 8
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co
);

  logic [BLK-1:0] g;
  logic [BLK-1:0] p;
  logic [BLK:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]ci, built without a ripple chain
  always_comb begin
    logic pp;
    pp   = 1'b1;
    c    = '0;
    c[0] = ci;
    for (int i = 1; i <= BLK; i++) begin
      pp   = 1'b1;
      c[i] = 1'b0;
      for (int j = i - 1; j >= 0; j--) begin
        c[i] = c[i] | (pp & g[j]);
        pp   = pp & p[j];
      end
      c[i] = c[i] | (pp & ci);
    end
  end

  assign s  = p ^ c[BLK-1:0];
  assign co = c[BLK];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined add/subtract built from cla_blk slices, STAGES register stages deep.
// Define CLA_PIPE_FLAGS_EN to add the registered ovf/zf flag outputs.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int BLK    = DEF_BLK,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef CLA_PIPE_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zf
`endif
);

  localparam int NBLK = WIDTH / BLK;
  localparam int SPS  = NBLK / STAGES;
  localparam int SW   = SPS * BLK;
  localparam int LAST = STAGES - 1;

  if ((WIDTH % BLK) != 0 || (NBLK % STAGES) != 0) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a multiple of BLK and WIDTH/BLK a multiple of STAGES");
  end

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  a_q  [STAGES];
  logic [WIDTH-1:0]  b_q  [STAGES];
  logic [WIDTH-1:0]  s_q  [STAGES];
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic [WIDTH-1:0]  s_nx [STAGES];
  logic              c_in [STAGES];
  logic              c_nx [STAGES];

  // Handshake: a beat moves across an interface on a rising edge where valid
  // and ready are both 1; a stage advances when empty or when the stage after it
  // advances, so in_ready may rise in the same cycle the output is drained.
  always_comb begin
    v_in      = '0;
    adv       = '0;
    v_in[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k] = v_q[k-1];
    end
    adv[LAST] = !v_q[LAST] || out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      adv[k] = !v_q[k] || adv[k+1];
    end
  end

  assign in_ready = !v_q[0] || adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SW;
    localparam logic [WIDTH-1:0] SMASK = WIDTH'({SW{1'b1}}) << LO;
    logic [SW-1:0] slice_s;

    if (k == 0) begin : g_head
      // Subtract is a + ~b + 1: invert b and force the carry-in.
      assign a_in[0] = a;
      assign b_in[0] = (op == OP_SUB) ? ~b : b;
      assign s_in[0] = '0;
      assign c_in[0] = (op == OP_SUB) ? 1'b1 : ci;
    end else begin : g_body
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign s_in[k] = s_q[k-1];
      assign c_in[k] = c_q[k-1];
    end

    for (genvar j = 0; j < SPS; j++) begin : g_slc
      localparam int LSB = LO + j * BLK;
      logic blk_ci;
      logic blk_co;

      if (j == 0) begin : g_first
        assign blk_ci = c_in[k];
      end else begin : g_next
        assign blk_ci = g_slc[j-1].blk_co;
      end

      cla_blk #(.BLK(BLK)) u_blk (
        .a  (a_in[k][LSB +: BLK]),
        .b  (b_in[k][LSB +: BLK]),
        .ci (blk_ci),
        .s  (slice_s[j*BLK +: BLK]),
        .co (blk_co)
      );
    end

    assign c_nx[k] = g_slc[SPS-1].blk_co;
    assign s_nx[k] = (s_in[k] & ~SMASK) | (WIDTH'(slice_s) << LO);
  end

  // Payload only loads with a valid beat so a bubble never disturbs s/co.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          v_q[k] <= v_in[k];
          if (v_in[k]) begin
            a_q[k] <= a_in[k];
            b_q[k] <= b_in[k];
            s_q[k] <= s_nx[k];
            c_q[k] <= c_nx[k];
          end
        end
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign s         = s_q[LAST];
  assign co        = c_q[LAST];

`ifdef CLA_PIPE_FLAGS_EN
  logic ovf_q;
  logic zf_q;

  // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      zf_q  <= 1'b0;
    end else if (adv[LAST] && v_in[LAST]) begin
      ovf_q <= a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1] ^ s_nx[LAST][WIDTH-1] ^ c_nx[LAST];
      zf_q  <= (s_nx[LAST] == '0);
    end
  end

  assign ovf = ovf_q;
  assign zf  = zf_q;
`endif

endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand/sum width in bits.
REQ-002 SHALL have parameter BLK, default 8: carry-lookahead slice width in bits.
REQ-003 SHALL have parameter STAGES, default 2: register stages, i.e. latency in cycles.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1: operands valid.
REQ-007 SHALL have port in_ready, output, 1: pipeline accepts operands this cycle.
REQ-008 SHALL have port a, input, WIDTH: operand A.
REQ-009 SHALL have port b, input, WIDTH: operand B.
REQ-010 SHALL have port ci, input, 1: carry in; ignored when op=1.
REQ-011 SHALL have port op, input, 1: 0 = add (a+b+ci), 1 = subtract (a-b).
REQ-012 SHALL have port out_valid, output, 1: result valid.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts result.
REQ-014 SHALL have port s, output, WIDTH: sum/difference.
REQ-015 SHALL have port co, output, 1: carry out of MSB (for subtract, 1 = no borrow).

Function
REQ-016 SHALL split operands into NBLK = WIDTH/BLK lookahead slices; stage k evaluates slices k*NBLK/STAGES .. (k+1)*NBLK/STAGES-1.
REQ-017 SHALL register the inter-stage carry and forward unprocessed operand bits and completed sum bits with each stage.
REQ-018 SHALL produce the result exactly STAGES cycles after acceptance when out_ready is held 1.
REQ-019 SHALL accept a transfer when in_valid && in_ready; SHALL deliver one when out_valid && out_ready.
REQ-020 SHALL advance stage k when it holds no data or when stage k+1 advances; the last stage advances when out_ready=1.
REQ-021 SHALL drive in_ready = !valid[0] || advance[0], giving one result per cycle under no backpressure.
REQ-022 SHALL hold s, co, out_valid stable while out_valid && !out_ready.
REQ-023 SHALL compute subtract as a + ~b + 1.
REQ-024 SHALL ensure accepted result count equals delivered result count plus occupied stages; no drop, no duplicate, order preserved.
REQ-025 SHALL accept a new transfer in the same cycle that a full pipeline delivers its oldest result.
REQ-026 SHALL have WIDTH%BLK==0 and NBLK%STAGES==0; SHALL stop elaboration otherwise.

Reset
REQ-027 SHALL, while reset_n=0, clear all stage valid bits, s, co and out_valid to 0 and drive in_ready to 1.
REQ-028 SHALL discard in-flight data when reset is asserted mid-operation; first result after release comes only from new input.

Configuration
REQ-029 SHALL, with CLA_PIPE_FLAGS_EN defined, add output ports ovf (signed overflow = carry into MSB XOR co) and zf (s==0), both 1 bit, registered with s, 0 at reset.
REQ-030 SHALL, without CLA_PIPE_FLAGS_EN, omit ovf and zf ports and their logic; all other behaviour is unchanged.

Structure
REQ-031 SHALL place the op encodings (OP_ADD=0, OP_SUB=1) and default WIDTH/BLK/STAGES constants in shared package cla_pkg.
REQ-032 SHALL implement each slice with sub-module cla_blk (BLK-bit lookahead: generate/propagate, sum, carry out), instanced NBLK times.

Verification
REQ-033 SHALL verify defaults, op=0, a=64'hFFFF_FFFF_FFFF_FFFF, b=1, ci=0 -> s=0, co=1 after 2 cycles (zf=1 when flags are enabled).
REQ-034 SHALL verify op=1, a=5, b=7 -> s=64'hFFFF_FFFF_FFFF_FFFE, co=0; a=7, b=5 -> s=2, co=1.
REQ-035 SHALL verify flags enabled, a=64'h7FFF_FFFF_FFFF_FFFF, b=1, op=0 -> s=64'h8000_0000_0000_0000, ovf=1, co=0.
REQ-036 SHALL verify 8 back-to-back transfers a=i, b=i, out_ready=1 -> in_ready constantly 1, outputs 0,2,..,14 on consecutive cycles.
REQ-037 SHALL verify out_ready=0 for 5 cycles while streaming -> in_ready drops after STAGES accepts, s held stable, no loss after release.
REQ-038 SHALL verify reset_n pulsed low with 2 results in flight -> out_valid=0, s=0 immediately, no stale result after release.
